// File: rtl/logic_pkg.sv
// ============================================================================
// Module      : logic_pkg
// Description : Opcode encodings and shared types for the bitwise logic unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package logic_pkg;

   localparam int OP_WIDTH = 3;

   localparam logic [OP_WIDTH-1:0] LOP_AND  = 3'b000;
   localparam logic [OP_WIDTH-1:0] LOP_OR   = 3'b001;
   localparam logic [OP_WIDTH-1:0] LOP_XOR  = 3'b010;
   localparam logic [OP_WIDTH-1:0] LOP_NOR  = 3'b011;
   localparam logic [OP_WIDTH-1:0] LOP_NOTA = 3'b100;
   localparam logic [OP_WIDTH-1:0] LOP_NAND = 3'b101;
   localparam logic [OP_WIDTH-1:0] LOP_XNOR = 3'b110;
   localparam logic [OP_WIDTH-1:0] LOP_ANDN = 3'b111;

   typedef struct packed {
      logic zero;
      logic ones;
      logic par;
   } flags_t;

endpackage

`default_nettype wire

// File: rtl/logic_core.sv
// ============================================================================
// Module      : logic_core (+ f_and, f_or, f_not, f_xor, f_nor gate cells)
// Description : Combinational op mux over the gate cells plus result flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module f_and #(parameter int W = 1) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = a_i & b_i;
endmodule

module f_or #(parameter int W = 1) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = a_i | b_i;
endmodule

module f_xor #(parameter int W = 1) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = a_i ^ b_i;
endmodule

module f_nor #(parameter int W = 1) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = ~(a_i | b_i);
endmodule

module f_not #(parameter int W = 1) (
   input  logic [W-1:0] a_i,
   output logic [W-1:0] y_o
);
   assign y_o = ~a_i;
endmodule

module logic_core
   import logic_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [OP_WIDTH-1:0]   op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] c_o,
   output flags_t                flags_o
);

   logic [DATA_WIDTH-1:0] w_and, w_or, w_xor, w_nor;
   logic [DATA_WIDTH-1:0] w_not_a, w_not_b, w_nand, w_xnor, w_andn;

   f_and #(.W(DATA_WIDTH)) u_and  (.a_i(a_i),   .b_i(b_i),     .y_o(w_and));
   f_or  #(.W(DATA_WIDTH)) u_or   (.a_i(a_i),   .b_i(b_i),     .y_o(w_or));
   f_xor #(.W(DATA_WIDTH)) u_xor  (.a_i(a_i),   .b_i(b_i),     .y_o(w_xor));
   f_nor #(.W(DATA_WIDTH)) u_nor  (.a_i(a_i),   .b_i(b_i),     .y_o(w_nor));
   f_not #(.W(DATA_WIDTH)) u_nota (.a_i(a_i),                  .y_o(w_not_a));
   f_not #(.W(DATA_WIDTH)) u_notb (.a_i(b_i),                  .y_o(w_not_b));
   // Inverted ops reuse the base gate outputs rather than separate cells.
   f_not #(.W(DATA_WIDTH)) u_nand (.a_i(w_and),                .y_o(w_nand));
   f_not #(.W(DATA_WIDTH)) u_xnor (.a_i(w_xor),                .y_o(w_xnor));
   f_and #(.W(DATA_WIDTH)) u_andn (.a_i(a_i),   .b_i(w_not_b), .y_o(w_andn));

   always_comb begin
      c_o = w_and;
      case (op_i)
         LOP_AND  : c_o = w_and;
         LOP_OR   : c_o = w_or;
         LOP_XOR  : c_o = w_xor;
         LOP_NOR  : c_o = w_nor;
         LOP_NOTA : c_o = w_not_a;
         LOP_NAND : c_o = w_nand;
         LOP_XNOR : c_o = w_xnor;
         LOP_ANDN : c_o = w_andn;
         default  : c_o = w_and;
      endcase
   end

   assign flags_o.zero = ~|c_o;
   assign flags_o.ones = &c_o;
   assign flags_o.par  = ^c_o;

endmodule

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage valid/ready bitwise logic unit with accumulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module logic_unit_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = logic_pkg::OP_WIDTH
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_WIDTH-1:0]   in_op,
   input  logic                  in_acc,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_c,
   output logic                  out_zero,
   output logic                  out_ones,
   output logic                  out_par
);

   logic                  s1_valid_q, s1_valid_d;
   logic [OP_WIDTH-1:0]   s1_op_q,    s1_op_d;
   logic                  s1_acc_q,   s1_acc_d;
   logic [DATA_WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [DATA_WIDTH-1:0] s1_b_q,     s1_b_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [DATA_WIDTH-1:0] s2_c_q,     s2_c_d;
   logic_pkg::flags_t     s2_flags_q, s2_flags_d;
   logic [DATA_WIDTH-1:0] acc_q,      acc_d;

   logic                  w_s2_adv, w_s1_adv, w_in_fire;
   logic [DATA_WIDTH-1:0] w_a_eff, w_c;
   logic_pkg::flags_t     w_flags;

   assign w_s2_adv  = !s2_valid_q || out_ready;
   assign w_s1_adv  = !s1_valid_q || w_s2_adv;
   assign w_in_fire = in_valid && w_s1_adv;

   // Accumulator is read when S1 evaluates, so a chained op sees its
   // predecessor's result, which was written into acc on the S2 load.
   assign w_a_eff = s1_acc_q ? acc_q : s1_a_q;

   logic_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
      .op_i    (s1_op_q),
      .a_i     (w_a_eff),
      .b_i     (s1_b_q),
      .c_o     (w_c),
      .flags_o (w_flags)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_acc_d   = s1_acc_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_c_d     = s2_c_q;
      s2_flags_d = s2_flags_q;
      acc_d      = acc_q;
      if (w_s1_adv) begin
         s1_valid_d = in_valid;
      end
      if (w_in_fire) begin
         s1_op_d  = in_op;
         s1_acc_d = in_acc;
         s1_a_d   = in_a;
         s1_b_d   = in_b;
      end
      if (w_s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_c_d     = w_c;
            s2_flags_d = w_flags;
            acc_d      = w_c;
         end
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_acc_q   <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_c_q     <= '0;
         s2_flags_q <= '0;
         acc_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_acc_q   <= s1_acc_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_c_q     <= s2_c_d;
         s2_flags_q <= s2_flags_d;
         acc_q      <= acc_d;
      end
   end

   assign in_ready  = w_s1_adv;
   assign out_valid = s2_valid_q;
   assign out_c     = s2_c_q;
   assign out_zero  = s2_flags_q.zero;
   assign out_ones  = s2_flags_q.ones;
   assign out_par   = s2_flags_q.par;

endmodule

`default_nettype wire
